// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared types for the memory-access stage.
// FSM state encoding and the MEM/WB bundle consumed by wb_stage.
package mem_stage_pkg;

    localparam int MEM_N = 32;
    localparam int MEM_R = 4;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_t;

    typedef struct packed {
        logic             valid;
        logic             reg_write;
        logic             wd_selector;
        logic [MEM_R-1:0] rd;
        logic [MEM_N-1:0] read_data;
        logic [MEM_N-1:0] alu_result;
    } mem_wb_t;

endpackage

// File: rtl/mem_stage_wb_reg.sv
// mem_wb_reg: MEM/WB pipeline register with load enable.
// Reset and clear both force a bubble (all fields zero).
import mem_stage_pkg::*;

module mem_wb_reg #(
    parameter type T = mem_wb_t
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    input  T     d,
    output T     q
);

    // Load, clear to bubble, or hold.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: load/store stage with req/ack data-memory handshake.
// Optional MEM_TIMEOUT_EN aborts a request after TIMEOUT wait cycles.
import mem_stage_pkg::*;

module mem_stage #(
    parameter int N       = MEM_N,
    parameter int R       = MEM_R,
    parameter int TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic         reg_write,
    input  logic         wd_selector,
    input  logic [R-1:0] rd,
    input  logic [N-1:0] alu_result,
    input  logic [N-1:0] write_data,
    output logic         stall,
    output logic         mem_req,
    output logic         mem_we,
    output logic [N-1:0] mem_addr,
    output logic [N-1:0] mem_wdata,
    input  logic         mem_ack,
    input  logic [N-1:0] mem_rdata,
    output logic         wb_valid,
    output logic         wb_reg_write,
    output logic         wb_wd_selector,
    output logic [R-1:0] wb_rd,
    output logic [N-1:0] wb_read_data,
    output logic [N-1:0] wb_alu_result,
    output logic         misaligned,
    output logic         mem_error
);

    mem_state_t   state;
    logic         lat_reg_write;
    logic         lat_wd_selector;
    logic [R-1:0] lat_rd;

    logic mem_op;
    logic aligned;
    logic accept;
    logic mis;
    logic tmo;

    mem_wb_t wb_d;
    mem_wb_t wb_q;
    logic    wb_en;
    logic    wb_clr;

    assign mem_op  = in_valid && (mem_read || mem_write);
    assign aligned = (alu_result[1:0] == 2'b00);
    assign accept  = (state == IDLE) && mem_op && aligned;
    assign mis     = (state == IDLE) && mem_op && !aligned;

`ifdef MEM_TIMEOUT_EN
    localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    logic [CW-1:0] wait_cnt;
    assign tmo = (state == WAIT) && !mem_ack
                 && (wait_cnt == CW'(TIMEOUT - 1));
`else
    assign tmo = 1'b0;
`endif

    assign stall = accept || ((state == WAIT) && !mem_ack);

    // Next MEM/WB contents: pass-through, bubble, or completed access.
    always_comb begin
        wb_d   = '0;
        wb_en  = 1'b1;
        wb_clr = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    wb_clr = 1'b1;
                end else begin
                    wb_d.valid       = in_valid;
                    wb_d.reg_write   = reg_write && !mis;
                    wb_d.wd_selector = wd_selector;
                    wb_d.rd          = rd;
                    wb_d.alu_result  = alu_result;
                end
            end
            WAIT: begin
                if (mem_ack || tmo) begin
                    wb_d.valid       = 1'b1;
                    wb_d.reg_write   = lat_reg_write && mem_ack;
                    wb_d.wd_selector = lat_wd_selector;
                    wb_d.rd          = lat_rd;
                    wb_d.alu_result  = mem_addr;
                    if (mem_ack && !mem_we) begin
                        wb_d.read_data = mem_rdata;
                    end
                end else begin
                    wb_en = 1'b0;
                end
            end
        endcase
    end

    mem_wb_reg #(.T(mem_wb_t)) u_wb (
        .clk (clk),
        .rst (rst),
        .en  (wb_en),
        .clr (wb_clr),
        .d   (wb_d),
        .q   (wb_q)
    );

    assign wb_valid       = wb_q.valid;
    assign wb_reg_write   = wb_q.reg_write;
    assign wb_wd_selector = wb_q.wd_selector;
    assign wb_rd          = wb_q.rd;
    assign wb_read_data   = wb_q.read_data;
    assign wb_alu_result  = wb_q.alu_result;

    // Request FSM: issue on accept, hold during WAIT, drop on ack/abort.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            mem_req         <= 1'b0;
            mem_we          <= 1'b0;
            mem_addr        <= '0;
            mem_wdata       <= '0;
            lat_reg_write   <= 1'b0;
            lat_wd_selector <= 1'b0;
            lat_rd          <= '0;
            misaligned      <= 1'b0;
            mem_error       <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            wait_cnt        <= '0;
`endif
        end else begin
            misaligned <= mis;
            mem_error  <= tmo;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        state           <= WAIT;
                        mem_req         <= 1'b1;
                        mem_we          <= mem_write;
                        mem_addr        <= alu_result;
                        mem_wdata       <= write_data;
                        lat_reg_write   <= reg_write;
                        lat_wd_selector <= wd_selector;
                        lat_rd          <= rd;
`ifdef MEM_TIMEOUT_EN
                        wait_cnt        <= '0;
`endif
                    end
                end
                WAIT: begin
                    if (mem_ack || tmo) begin
                        state   <= IDLE;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                    end else begin
`ifdef MEM_TIMEOUT_EN
                        wait_cnt <= wait_cnt + 1'b1;
`endif
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the ASIP pipeline, between the EX/MEM boundary and `wb_stage`. It issues load/store requests to a variable-latency data memory over a req/ack handshake and stalls upstream while a request is outstanding. It also registers the MEM/WB outputs (`read_data`, `alu_result`, `wd_selector`, destination register) that the write-back mux consumes.

## Interface
- `N`, 32: data/address width.
- `R`, 4: register-index width.
- `TIMEOUT`, 255: maximum WAIT cycles before abort (used only with the macro).
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  instruction present from EX.
- `mem_read`, `mem_write`  in  1  load / store (never both).
- `reg_write`  in  1  instruction writes the register file.
- `wd_selector`  in  1  1 = write-back ALU result, 0 = memory data.
- `rd`  in  R  destination register.
- `alu_result`  in  N  ALU result, also the byte address.
- `write_data`  in  N  store data.
- `stall`  out  1  upstream must hold its inputs (combinational).
- `mem_req`, `mem_we`  out  1  memory request / write enable (registered).
- `mem_addr`, `mem_wdata`  out  N  request address / store data (registered).
- `mem_ack`  in  1  request completed this cycle.
- `mem_rdata`  in  N  load data, valid with `mem_ack`.
- `wb_valid`, `wb_reg_write`, `wb_wd_selector`  out  1  MEM/WB control.
- `wb_rd`  out  R;  `wb_read_data`, `wb_alu_result`  out  N  MEM/WB data.
- `misaligned`  out  1  one-cycle pulse: access dropped because `alu_result[1:0] != 0`.
- `mem_error`  out  1  one-cycle pulse: request timed out.

## Operation
- Two states: IDLE and WAIT.
- **IDLE, no memory op** (`in_valid` with neither `mem_read` nor `mem_write`, or `!in_valid`):
  - Next cycle the MEM/WB register loads the inputs. `wb_valid` = `in_valid`; `wb_read_data` = 0.
- **IDLE, aligned memory op** (`in_valid` & (`mem_read` | `mem_write`) & `alu_result[1:0]==0`):
  - Latch control fields, address and data.
  - Next cycle: `mem_req`=1, `mem_we`=`mem_write`, `mem_addr`=`alu_result`, `mem_wdata`=`write_data`; go to WAIT.
  - The MEM/WB register loads a bubble (`wb_valid`=0).
- **IDLE, misaligned memory op:**
  - No request; pulse `misaligned`.
  - MEM/WB loads the instruction with `wb_reg_write` forced to 0.
- **WAIT:**
  - `mem_req`, `mem_we`, `mem_addr`, `mem_wdata` are held stable.
  - Inputs are ignored; the latched copy is used.
  - On `mem_ack`: `mem_req` drops next cycle; MEM/WB loads the latched fields with `wb_read_data`=`mem_rdata` (0 for stores); return to IDLE.
- `stall` = (IDLE & `in_valid` & aligned memory op) | (WAIT & `!mem_ack`).
- `mem_ack` in IDLE is spurious and is ignored.
- MEM/WB loads only when the stage is not holding a bubble, per the rules above.

## Timing
- Reset values: state IDLE; every output 0, including `mem_*`, `wb_*`, `misaligned` and `mem_error`.
- Non-memory instruction: 1-cycle latency to `wb_*`.
- Memory op, with ack k cycles after `mem_req` rises (k ≥ 0, where k=0 means ack in the first WAIT cycle):
  - `wb_valid` rises k+2 cycles after acceptance.
  - `stall` is high for k+1 cycles.
- The ack cycle has `stall`=0, so upstream advances and the next instruction is seen in IDLE on the following cycle.
- `rst` mid-WAIT: `mem_req` drops on the next edge and the latched operation is discarded. The memory must tolerate an abandoned request.

## Configuration
- `MEM_TIMEOUT_EN` defined:
  - An 8+-bit counter clears on entry to WAIT and increments each WAIT cycle without ack.
  - When the counter reaches `TIMEOUT`: `mem_req` drops, `mem_error` pulses, MEM/WB loads the instruction with `wb_reg_write`=0, and the state returns to IDLE.
  - If ack and timeout occur in the same cycle, ack wins.
- `MEM_TIMEOUT_EN` undefined: no counter; WAIT is unbounded; `mem_error` is tied to 0.

## Structure
- `mem_stage_pkg`: state enum typedef `mem_state_t` (IDLE, WAIT) and the MEM/WB bundle struct `mem_wb_t`.
- Sub-module `mem_wb_reg`: parameterised enable/synchronous-clear register holding `mem_wb_t`.
- FSM, latch and timeout logic stay in `mem_stage`.

## Test plan
- Reset for 2 cycles → all outputs 0. Then ALU op (`alu_result`=0x0000_0042, `rd`=3, `wd_selector`=1) → next cycle `wb_valid`=1, `wb_alu_result`=0x42, `stall` never high.
- Load at 0x100, `mem_ack` with `mem_rdata`=0xDEAD_BEEF 3 cycles after `mem_req` → `stall` high 4 cycles, address held stable, `wb_read_data`=0xDEAD_BEEF, `wb_valid` 5 cycles after acceptance.
- Store at 0x104, data 0x1234, ack in first WAIT cycle → `mem_we`=1, `mem_wdata`=0x1234, `wb_reg_write`=0, single stall cycle pair as specified.
- Load at 0x102 → `misaligned` pulse, `mem_req` stays 0, `wb_reg_write`=0, no stall.
- Load, `rst` asserted during WAIT → `mem_req`=0 next cycle; a later ack is ignored; the next ALU op completes normally.
- With `MEM_TIMEOUT_EN` and `TIMEOUT`=4, no ack → `mem_error` pulses after 4 WAIT cycles, `stall` releases, `wb_reg_write`=0. A second run with ack on cycle 4 → data captured, `mem_error` stays 0.
